// File: rtl/codec_write_buffer.sv
// Stereo FIFO between the FIR outputs and the CODEC write port.
// Pre-fills before playback, counts underruns and issues a registered write strobe.
//
// state  | meaning
// S_FILL | collecting PREFILL pairs, no writes to the CODEC
// S_RUN  | popping one pair per write_ready cycle while data remains
module codec_write_buffer #(
  parameter int M       = 24,
  parameter int DEPTH   = 8,
  parameter int PREFILL = 4
) (
  input  logic                   ck,
  input  logic                   rst_n,
  input  logic [M-1:0]           in_left,
  input  logic [M-1:0]           in_right,
  input  logic                   in_valid,
  input  logic                   write_ready,
  output logic                   write,
  output logic [23:0]            out_left,
  output logic [23:0]            out_right,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  output logic [15:0]            underruns
);

  localparam int PW  = $clog2(DEPTH);
  localparam int LW  = PW + 1;
  localparam int PAD = 24 - M;
  localparam logic [LW-1:0] L_DEPTH   = LW'(DEPTH);
  localparam logic [LW-1:0] L_PREFILL = LW'(PREFILL);

  typedef enum logic {S_FILL, S_RUN} state_t;

  state_t           r_state;
  logic [2*M-1:0]   r_mem [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [LW-1:0]    r_level;
  logic             r_write;
  logic [23:0]      r_out_left;
  logic [23:0]      r_out_right;
  logic             r_overflow;
  logic [15:0]      r_underruns;

  logic             w_pop;
  logic             w_push;
  logic             w_underrun;
  logic [M-1:0]     w_rd_left;
  logic [M-1:0]     w_rd_right;

  // A full buffer still accepts a push when a pop frees a slot on the same edge.
  assign w_pop      = (r_state == S_RUN) && write_ready && (r_level != '0);
  assign w_push     = in_valid && ((r_level != L_DEPTH) || w_pop);
  assign w_underrun = (r_state == S_RUN) && write_ready && (r_level == '0) && !in_valid;
  assign w_rd_left  = r_mem[r_rptr][2*M-1:M];
  assign w_rd_right = r_mem[r_rptr][M-1:0];

  always_ff @(posedge ck) begin
    if (w_push)
      r_mem[r_wptr] <= {in_left, in_right};
  end

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_FILL;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_level     <= '0;
      r_write     <= 1'b0;
      r_out_left  <= '0;
      r_out_right <= '0;
      r_overflow  <= 1'b0;
      r_underruns <= '0;
    end else begin
      r_write <= w_pop;
      if (w_push)
        r_wptr <= r_wptr + PW'(1);
      if (w_pop) begin
        r_rptr      <= r_rptr + PW'(1);
        r_out_left  <= 24'(w_rd_left) << PAD;
        r_out_right <= 24'(w_rd_right) << PAD;
      end
      if (w_push && !w_pop)
        r_level <= r_level + LW'(1);
      else if (!w_push && w_pop)
        r_level <= r_level - LW'(1);
      if (in_valid && !w_push)
        r_overflow <= 1'b1;
      case (r_state)
        S_FILL: begin
          if (r_level >= L_PREFILL)
            r_state <= S_RUN;
        end
        S_RUN: begin
          if (w_underrun) begin
            r_state <= S_FILL;
            if (r_underruns != 16'hFFFF)
              r_underruns <= r_underruns + 16'd1;
          end
        end
        default: r_state <= S_FILL;
      endcase
    end
  end

  assign write     = r_write;
  assign out_left  = r_out_left;
  assign out_right = r_out_right;
  assign level     = r_level;
  assign overflow  = r_overflow;
  assign underruns = r_underruns;

endmodule

// File: tb/tb_codec_write_buffer.sv
// Directed bench for codec_write_buffer: a 24-bit/DEPTH 8/PREFILL 4 instance
// plus a 16-bit/PREFILL 1 instance for the MSB-alignment case.
module tb_codec_write_buffer;

  logic        ck;
  logic        rst_n;
  logic [23:0] in_left, in_right;
  logic        in_valid, write_ready;
  logic        write;
  logic [23:0] out_left, out_right;
  logic [3:0]  level;
  logic        overflow;
  logic [15:0] underruns;

  logic [15:0] b_in_left, b_in_right;
  logic        b_in_valid, b_write_ready;
  logic        b_write;
  logic [23:0] b_out_left, b_out_right;
  logic [2:0]  b_level;
  logic        b_overflow;
  logic [15:0] b_underruns;

  int checks = 0;
  int errors = 0;

  codec_write_buffer #(.M(24), .DEPTH(8), .PREFILL(4)) dut (
    .ck(ck), .rst_n(rst_n), .in_left(in_left), .in_right(in_right),
    .in_valid(in_valid), .write_ready(write_ready), .write(write),
    .out_left(out_left), .out_right(out_right), .level(level),
    .overflow(overflow), .underruns(underruns)
  );

  codec_write_buffer #(.M(16), .DEPTH(4), .PREFILL(1)) dut16 (
    .ck(ck), .rst_n(rst_n), .in_left(b_in_left), .in_right(b_in_right),
    .in_valid(b_in_valid), .write_ready(b_write_ready), .write(b_write),
    .out_left(b_out_left), .out_right(b_out_right), .level(b_level),
    .overflow(b_overflow), .underruns(b_underruns)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0; write_ready = 1'b0; in_left = '0; in_right = '0;
    b_in_valid = 1'b0; b_write_ready = 1'b0; b_in_left = '0; b_in_right = '0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0; write_ready = 1'b0; in_left = '0; in_right = '0;
    b_in_valid = 1'b0; b_write_ready = 1'b0; b_in_left = '0; b_in_right = '0;
    #2;
    checks++;
    if (write !== 1'b0 || level !== 4'd0 || overflow !== 1'b0 || underruns !== 16'd0 ||
        out_left !== 24'd0 || out_right !== 24'd0) begin
      errors++;
      $display("FAIL reset_state got w=%b lvl=%0d ovf=%b und=%0d l=%h r=%h want all 0",
               write, level, overflow, underruns, out_left, out_right);
    end
    checks++;
    if (b_write !== 1'b0 || b_level !== 3'd0 || b_out_left !== 24'd0) begin
      errors++;
      $display("FAIL reset_state16 got w=%b lvl=%0d l=%h want 0", b_write, b_level, b_out_left);
    end
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_prefill();
    do_reset();
    write_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      in_valid = 1'b1; in_left = 24'h000101 * i; in_right = 24'h000202 * i;
      tick();
      checks++;
      if (write !== 1'b0 || level !== 4'(i)) begin
        errors++;
        $display("FAIL prefill_push%0d got w=%b lvl=%0d want w=0 lvl=%0d", i, write, level, i);
      end
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (write !== 1'b0 || level !== 4'd3) begin
      errors++;
      $display("FAIL prefill_hold got w=%b lvl=%0d want w=0 lvl=3", write, level);
    end
    in_valid = 1'b1; in_left = 24'h000404; in_right = 24'h000808;
    tick();
    in_valid = 1'b0;
    checks++;
    if (write !== 1'b0 || level !== 4'd4) begin
      errors++;
      $display("FAIL prefill_4th got w=%b lvl=%0d want w=0 lvl=4", write, level);
    end
    tick();
    checks++;
    if (write !== 1'b0 || level !== 4'd4) begin
      errors++;
      $display("FAIL prefill_to_run got w=%b lvl=%0d want w=0 lvl=4", write, level);
    end
    tick();
    checks++;
    if (write !== 1'b1 || out_left !== 24'h000101 || out_right !== 24'h000202 || level !== 4'd3) begin
      errors++;
      $display("FAIL prefill_first_write got w=%b l=%h r=%h lvl=%0d want w=1 l=000101 r=000202 lvl=3",
               write, out_left, out_right, level);
    end
    write_ready = 1'b0;
    tick();
    checks++;
    if (write !== 1'b0 || out_left !== 24'h000101 || out_right !== 24'h000202) begin
      errors++;
      $display("FAIL prefill_hold_out got w=%b l=%h r=%h want w=0 l=000101 r=000202",
               write, out_left, out_right);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_left = 24'h100000 + 24'(i); in_right = 24'h200000 + 24'(i);
      tick();
    end
    checks++;
    if (level !== 4'd8 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_full got lvl=%0d ovf=%b want lvl=8 ovf=0", level, overflow);
    end
    in_left = 24'hAAAAAA; in_right = 24'hAAAAAA;
    tick();
    checks++;
    if (level !== 4'd8 || overflow !== 1'b1 || write !== 1'b0) begin
      errors++;
      $display("FAIL ovf_drop got lvl=%0d ovf=%b w=%b want lvl=8 ovf=1 w=0", level, overflow, write);
    end
    in_left = 24'h0000BB; in_right = 24'h0000CC; write_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++;
    if (level !== 4'd8 || write !== 1'b1 || out_left !== 24'h100000 || out_right !== 24'h200000) begin
      errors++;
      $display("FAIL ovf_push_pop got lvl=%0d w=%b l=%h r=%h want lvl=8 w=1 l=100000 r=200000",
               level, write, out_left, out_right);
    end
    for (int i = 1; i < 8; i++) begin
      tick();
      checks++;
      if (write !== 1'b1 || out_left !== 24'h100000 + 24'(i) || out_right !== 24'h200000 + 24'(i)) begin
        errors++;
        $display("FAIL ovf_drain%0d got w=%b l=%h r=%h want w=1 l=%h r=%h", i, write, out_left,
                 out_right, 24'h100000 + 24'(i), 24'h200000 + 24'(i));
      end
    end
    tick();
    write_ready = 1'b0;
    checks++;
    if (write !== 1'b1 || out_left !== 24'h0000BB || out_right !== 24'h0000CC || level !== 4'd0) begin
      errors++;
      $display("FAIL ovf_last got w=%b l=%h r=%h lvl=%0d want w=1 l=0000bb r=0000cc lvl=0",
               write, out_left, out_right, level);
    end
  endtask

  task automatic test_underrun();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_left = 24'h030000 + 24'(i); in_right = 24'h031000 + 24'(i);
      tick();
    end
    in_valid = 1'b0;
    tick();
    write_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (write !== 1'b1 || out_left !== 24'h030000 + 24'(i) || level !== 4'(3 - i)) begin
        errors++;
        $display("FAIL udr_drain%0d got w=%b l=%h lvl=%0d want w=1 l=%h lvl=%0d", i, write,
                 out_left, level, 24'h030000 + 24'(i), 3 - i);
      end
    end
    checks++;
    if (underruns !== 16'd0) begin
      errors++;
      $display("FAIL udr_before got %0d want 0", underruns);
    end
    tick();
    checks++;
    if (write !== 1'b0 || underruns !== 16'd1) begin
      errors++;
      $display("FAIL udr_event got w=%b und=%0d want w=0 und=1", write, underruns);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (write !== 1'b0 || underruns !== 16'd1) begin
        errors++;
        $display("FAIL udr_idle%0d got w=%b und=%0d want w=0 und=1", i, write, underruns);
      end
    end
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_left = 24'h0E0000 + 24'(i); in_right = 24'h0E1000 + 24'(i);
      tick();
      checks++;
      if (write !== 1'b0) begin
        errors++;
        $display("FAIL udr_refill%0d got w=%b want w=0", i, write);
      end
    end
    in_valid = 1'b0;
    tick();
    tick();
    write_ready = 1'b0;
    checks++;
    if (write !== 1'b1 || out_left !== 24'h0E0000 || out_right !== 24'h0E1000 || underruns !== 16'd1) begin
      errors++;
      $display("FAIL udr_resume got w=%b l=%h r=%h und=%0d want w=1 l=0e0000 r=0e1000 und=1",
               write, out_left, out_right, underruns);
    end
  endtask

  // Write_ready tracks the push cadence so the buffer neither starves nor fills.
  task automatic test_wrap();
    int received;
    received = 0;
    do_reset();
    for (int j = 0; j < 20; j++) begin
      for (int c = 0; c < 3; c++) begin
        in_valid = (c == 0); write_ready = (c == 0);
        in_left = 24'h040000 + 24'(j); in_right = 24'h050000 + 24'(j);
        tick();
        if (write) begin
          checks++;
          if (out_left !== 24'h040000 + 24'(received) || out_right !== 24'h050000 + 24'(received)) begin
            errors++;
            $display("FAIL wrap_order%0d got l=%h r=%h want l=%h r=%h", received, out_left,
                     out_right, 24'h040000 + 24'(received), 24'h050000 + 24'(received));
          end
          received++;
        end
      end
    end
    in_valid = 1'b0;
    write_ready = 1'b1;
    for (int c = 0; c < 20 && received < 20; c++) begin
      tick();
      if (write) begin
        checks++;
        if (out_left !== 24'h040000 + 24'(received) || out_right !== 24'h050000 + 24'(received)) begin
          errors++;
          $display("FAIL wrap_order%0d got l=%h r=%h want l=%h r=%h", received, out_left,
                   out_right, 24'h040000 + 24'(received), 24'h050000 + 24'(received));
        end
        received++;
      end
      if (received == 20) write_ready = 1'b0;
    end
    write_ready = 1'b0;
    checks++;
    if (received !== 20 || underruns !== 16'd0 || level !== 4'd0) begin
      errors++;
      $display("FAIL wrap_total got n=%0d und=%0d lvl=%0d want n=20 und=0 lvl=0",
               received, underruns, level);
    end
  endtask

  task automatic test_m16();
    do_reset();
    b_write_ready = 1'b1;
    b_in_valid = 1'b1; b_in_left = 16'h8001; b_in_right = 16'h00FF;
    tick();
    b_in_valid = 1'b0;
    checks++;
    if (b_level !== 3'd1 || b_write !== 1'b0) begin
      errors++;
      $display("FAIL m16_push got lvl=%0d w=%b want lvl=1 w=0", b_level, b_write);
    end
    tick();
    tick();
    b_write_ready = 1'b0;
    checks++;
    if (b_write !== 1'b1 || b_out_left !== 24'h800100 || b_out_right !== 24'h00FF00) begin
      errors++;
      $display("FAIL m16_align got w=%b l=%h r=%h want w=1 l=800100 r=00ff00",
               b_write, b_out_left, b_out_right);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 9; i++) begin
      in_valid = 1'b1; in_left = 24'h060000 + 24'(i); in_right = 24'h061000 + 24'(i);
      tick();
    end
    in_valid = 1'b0;
    write_ready = 1'b1;
    tick();
    tick();
    tick();
    write_ready = 1'b0;
    checks++;
    if (level !== 4'd5 || write !== 1'b1 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL arst_pre got lvl=%0d w=%b ovf=%b want lvl=5 w=1 ovf=1", level, write, overflow);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (write !== 1'b0 || level !== 4'd0 || overflow !== 1'b0 || underruns !== 16'd0 || out_left !== 24'd0) begin
      errors++;
      $display("FAIL arst_clear got w=%b lvl=%0d ovf=%b und=%0d l=%h want all 0",
               write, level, overflow, underruns, out_left);
    end
    #2;
    rst_n = 1'b1;
    tick();
    write_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_left = 24'h0F0000 + 24'(i); in_right = 24'h0F1000 + 24'(i);
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if (level !== 4'd4 || write !== 1'b0) begin
      errors++;
      $display("FAIL arst_refill got lvl=%0d w=%b want lvl=4 w=0", level, write);
    end
    tick();
    tick();
    write_ready = 1'b0;
    checks++;
    if (write !== 1'b1 || out_left !== 24'h0F0000 || out_right !== 24'h0F1000) begin
      errors++;
      $display("FAIL arst_first got w=%b l=%h r=%h want w=1 l=0f0000 r=0f1000",
               write, out_left, out_right);
    end
  endtask

  initial begin
    test_reset();
    test_prefill();
    test_overflow();
    test_underrun();
    test_wrap();
    test_m16();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
